// File: rtl/nios_ii_key_pkg.sv
// Shared constants for the key/switch input PIO: register addresses and
// edge-select encodings.
package nios_ii_key_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/nios_ii_key_debounce.sv
// One input bit: two-flop synchroniser followed by a hold-time debouncer.
// A new level is accepted only after it has been seen for DEBOUNCE_CYCLES
// consecutive cycles; any return to the accepted level restarts the count.
module nios_ii_key_debounce
   import nios_ii_key_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic RESET_VAL       = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_in,
   output logic o_stable
);

   localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_stable;
   logic [CW-1:0] r_cnt;

   // Synchronise the pin, then count how long it has disagreed with the accepted level.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sync1  <= RESET_VAL;
         r_sync2  <= RESET_VAL;
         r_stable <= RESET_VAL;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= i_in;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_stable = r_stable;

endmodule

// File: rtl/nios_ii_key_pio.sv
// Avalon-MM input PIO for push-buttons and switches. Debounced levels, a
// per-bit edge capture register and an interrupt mask; irq is the OR of
// masked captured edges.
// Build option: NIOS_II_KEY_BITCLR_EN -- when defined, an EDGECAP write clears
// only the bits set in writedata; otherwise any EDGECAP write clears all bits.
module nios_ii_key_pio
   import nios_ii_key_pkg::*;
#(
   parameter int               WIDTH           = 4,
   parameter int               DEBOUNCE_CYCLES = 50000,
   parameter int               EDGE_TYPE       = 1,
   parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] w_stable;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] w_clr;
   logic             w_wr_mask;
   logic             w_wr_cap;
   logic [31:0]      w_rdata;
   logic             w_unused;

   logic [WIDTH-1:0] r_stable_d;
   logic [WIDTH-1:0] r_mask;
   logic [WIDTH-1:0] r_cap;
   logic [31:0]      r_readdata;

   genvar g;
   generate
      for (g = 0; g < WIDTH; g++) begin : g_bit
         nios_ii_key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (RESET_LEVEL[g])
         ) u_db (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_in     (in_port[g]),
            .o_stable (w_stable[g])
         );
      end
   endgenerate

   assign w_rise    = w_stable & ~r_stable_d;
   assign w_fall    = r_stable_d & ~w_stable;
   assign w_wr_mask = chipselect & ~write_n & (address == ADDR_IRQMASK);
   assign w_wr_cap  = chipselect & ~write_n & (address == ADDR_EDGECAP);
   // Upper writedata bits are deliberately ignored.
   assign w_unused  = &{1'b0, writedata};

   // Select which debounced transitions count as a capture event.
   always_comb begin
      w_edge = w_rise | w_fall;
      if (EDGE_TYPE == EDGE_RISING)       w_edge = w_rise;
      else if (EDGE_TYPE == EDGE_FALLING) w_edge = w_fall;
   end

   // Bits cleared by an EDGECAP write this cycle.
   always_comb begin
`ifdef NIOS_II_KEY_BITCLR_EN
      w_clr = w_wr_cap ? writedata[WIDTH-1:0] : '0;
`else
      w_clr = {WIDTH{w_wr_cap}};
`endif
   end

   // Read mux; unmapped addresses and bits above WIDTH read zero.
   always_comb begin
      w_rdata = '0;
      case (address)
         ADDR_DATA:    w_rdata[WIDTH-1:0] = w_stable;
         ADDR_IRQMASK: w_rdata[WIDTH-1:0] = r_mask;
         ADDR_EDGECAP: w_rdata[WIDTH-1:0] = r_cap;
         default:      w_rdata = '0;
      endcase
   end

   // Edge history, mask, capture (set beats clear) and registered read data.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_stable_d <= RESET_LEVEL;
         r_mask     <= '0;
         r_cap      <= '0;
         r_readdata <= '0;
      end else begin
         r_stable_d <= w_stable;
         if (w_wr_mask) r_mask <= writedata[WIDTH-1:0];
         r_cap      <= (r_cap & ~w_clr) | w_edge;
         r_readdata <= w_rdata;
      end
   end

   assign readdata = r_readdata;
   assign irq      = |(r_cap & r_mask);

endmodule

// File: tb/tb_nios_ii_key_pio.sv
// Bench for nios_ii_key_pio (WIDTH=4, DEBOUNCE_CYCLES=4, falling edges).
// A cycle-level model derives the accepted level from a sliding window of
// synchronised pin samples and checks readdata/irq every cycle; directed
// reads pin the model with hand-computed values.
module tb_nios_ii_key_pio;

   localparam int            W  = 4;
   localparam int            D  = 4;
   localparam int            ET = 1;
   localparam logic [W-1:0]  RL = '1;
`ifdef NIOS_II_KEY_BITCLR_EN
   localparam logic [31:0]   EXP_BITCLR = 32'h4;
`else
   localparam logic [31:0]   EXP_BITCLR = 32'h0;
`endif

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [1:0]   address = 2'd0;
   logic         chipselect = 1'b0;
   logic         write_n = 1'b1;
   logic [31:0]  writedata = 32'h0;
   logic [W-1:0] in_port = '1;
   wire  [31:0]  readdata;
   wire          irq;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   nios_ii_key_pio #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (D),
      .EDGE_TYPE       (ET),
      .RESET_LEVEL     (RL)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   // ---------------- behavioural model ----------------
   logic [W-1:0] m_p1, m_p2, m_stable, m_prev, m_cap, m_mask;
   logic [W-1:0] m_win [D];
   logic [31:0]  m_rd;
   bit           m_ok = 1'b0;

   always @(posedge clk) begin : model
      logic [W-1:0] sync, set, clr, ns;
      bit flip;
      if (!reset_n) begin
         m_p1 = RL; m_p2 = RL; m_stable = RL; m_prev = RL;
         m_cap = '0; m_mask = '0; m_rd = '0;
         for (int j = 0; j < D; j++) m_win[j] = RL;
         m_ok = 1'b1;
      end else begin
         case (address)
            2'd0:    m_rd = 32'(m_stable);
            2'd2:    m_rd = 32'(m_mask);
            2'd3:    m_rd = 32'(m_cap);
            default: m_rd = 32'h0;
         endcase
         set = (ET == 0) ? (m_stable & ~m_prev) :
               (ET == 1) ? (m_prev & ~m_stable) : (m_stable ^ m_prev);
         clr = '0;
         if (chipselect && !write_n && address == 2'd3) begin
`ifdef NIOS_II_KEY_BITCLR_EN
            clr = writedata[W-1:0];
`else
            clr = '1;
`endif
         end
         m_cap = (m_cap & ~clr) | set;
         if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
         // pin seen two edges late, then needs D identical samples against the accepted level
         sync = m_p2; m_p2 = m_p1; m_p1 = in_port;
         for (int j = D - 1; j > 0; j--) m_win[j] = m_win[j-1];
         m_win[0] = sync;
         ns = m_stable;
         for (int i = 0; i < W; i++) begin
            flip = 1'b1;
            for (int j = 0; j < D; j++) if (m_win[j][i] == m_stable[i]) flip = 1'b0;
            if (flip) ns[i] = ~m_stable[i];
         end
         m_prev   = m_stable;
         m_stable = ns;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (m_ok) begin
         n_cmp++;
         if (readdata !== m_rd || irq !== (|(m_cap & m_mask))) begin
            n_err++;
            $display("FAIL model t=%0t readdata=%h irq=%b expected readdata=%h irq=%b",
                     $time, readdata, irq, m_rd, |(m_cap & m_mask));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); @(negedge clk); end
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
      address = a;
      cyc(1);
      chk(nm, readdata, exp);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      cyc(1);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      cyc(3);
      reset_n = 1'b1;

      rd(2'd0, 32'hF, "reset_data");
      rd(2'd2, 32'h0, "reset_mask");
      rd(2'd3, 32'h0, "reset_edgecap");
      chk("reset_irq", {31'b0, irq}, 32'h0);

      // key 0 pressed: 2 sync + 4 debounce edges, then one read-register edge
      address = 2'd0;
      in_port[0] = 1'b0;
      cyc(6);
      chk("data_before_latency", readdata, 32'hF);
      cyc(1);
      chk("data_after_latency", readdata, 32'hE);
      rd(2'd3, 32'h1, "edgecap_bit0");
      chk("irq_masked_off", {31'b0, irq}, 32'h0);

      wr(2'd2, 32'h1);
      chk("irq_after_mask", {31'b0, irq}, 32'h1);
      wr(2'd3, 32'h1);
      chk("irq_after_clear", {31'b0, irq}, 32'h0);
      rd(2'd3, 32'h0, "edgecap_cleared");

      // 3-cycle glitch on key 1 is rejected
      in_port[0] = 1'b1;
      cyc(10);
      in_port[1] = 1'b0;
      cyc(3);
      in_port[1] = 1'b1;
      cyc(10);
      rd(2'd0, 32'hF, "glitch_data");
      rd(2'd3, 32'h0, "glitch_edgecap");

      // two captures, then a write of 0x1
      in_port[0] = 1'b0; in_port[2] = 1'b0;
      cyc(10);
      rd(2'd3, 32'h5, "edgecap_two_bits");
      wr(2'd3, 32'h1);
      rd(2'd3, EXP_BITCLR, "edgecap_write_0x1");

      // clear write lands on the same edge as a new bit-2 capture
      in_port[0] = 1'b1; in_port[2] = 1'b1;
      cyc(10);
      in_port[2] = 1'b0;
      cyc(6);
      wr(2'd3, 32'hF);
      rd(2'd3, 32'h4, "set_wins");

      // reset pulse in the middle of a debounce count
      in_port[2] = 1'b1;
      cyc(10);
      wr(2'd3, 32'hF);
      in_port[3] = 1'b0;
      cyc(4);
      reset_n = 1'b0; in_port = '1;
      cyc(1);
      reset_n = 1'b1;
      cyc(10);
      rd(2'd0, 32'hF, "reset_mid_data");
      rd(2'd3, 32'h0, "reset_mid_edgecap");
      rd(2'd2, 32'h0, "reset_mid_mask");
      chk("reset_mid_irq", {31'b0, irq}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
